// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data memory controller.
// Optional parity support (DMEM_PARITY_EN) uses the parity() helper.
package dmem_pkg;

   typedef enum logic {CLEAR, RUN} state_t;

   // Even-parity bit; callers zero-extend narrower words, which leaves the result unchanged.
   function automatic logic parity(input logic [63:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/dmem_clear_seq.sv
// Post-reset clear sequencer: sweeps every address once, then parks in RUN until the next reset.
// Owns the FSM, the sweep counter and init_busy.
module dmem_clear_seq
   import dmem_pkg::*;
#(
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr,
   output logic              init_busy
);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_cnt;
   logic [ADDR_W-1:0] w_cnt_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= CLEAR;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      clr_we      = 1'b0;
      clr_addr    = r_cnt;
      init_busy   = 1'b0;
      case (r_state)
         CLEAR: begin
            clr_we    = 1'b1;
            init_busy = 1'b1;
            w_cnt_nxt = r_cnt + 1'b1;
            // Last word is written on this edge; busy drops the cycle after.
            if (r_cnt == {ADDR_W{1'b1}}) w_state_nxt = RUN;
         end
         RUN: ;
         default: w_state_nxt = CLEAR;
      endcase
   end

endmodule

// File: rtl/data_mem_ctrl.sv
// Simple dual-port data memory with post-reset clear sweep, write-protected low region,
// registered read with write-first bypass. Define DMEM_PARITY_EN for per-word parity and rd_perr.
module data_mem_ctrl
   import dmem_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 5,
   parameter int PROT_TOP  = 16,
   parameter int CLEAR_VAL = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              init_busy,
   output logic              wr_err
`ifdef DMEM_PARITY_EN
  ,output logic              rd_perr
`endif
);

   localparam int              DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W:0] P_TOP = (ADDR_W+1)'(PROT_TOP);
   localparam logic [DATA_W-1:0] P_CLR = DATA_W'(CLEAR_VAL);

   logic [DATA_W-1:0] r_mem [DEPTH];

   logic              w_clr_we;
   logic [ADDR_W-1:0] w_clr_addr;
   logic              w_prot;
   logic              w_user_we;
   logic              w_rd_acc;
   logic              w_bypass;
   logic              w_we;
   logic [ADDR_W-1:0] w_waddr;
   logic [DATA_W-1:0] w_wdata;
   logic [DATA_W-1:0] w_rd_word;

   dmem_clear_seq #(.ADDR_W(ADDR_W)) u_clear_seq (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_we    (w_clr_we),
      .clr_addr  (w_clr_addr),
      .init_busy (init_busy)
   );

   // PROT_TOP of 0 makes the comparison always false, disabling protection.
   assign w_prot    = ({1'b0, wr_addr} < P_TOP);
   assign w_user_we = wr_en & ~init_busy & ~w_prot;
   assign w_rd_acc  = rd_en & ~init_busy;
   assign w_bypass  = w_user_we & (wr_addr == rd_addr);

   assign w_we    = w_clr_we | w_user_we;
   assign w_waddr = w_clr_we ? w_clr_addr : wr_addr;
   assign w_wdata = w_clr_we ? P_CLR      : wr_data;

   always_ff @(posedge clk) begin
      if (w_we) r_mem[w_waddr] <= w_wdata;
   end

   assign w_rd_word = w_bypass ? wr_data : r_mem[rd_addr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
         wr_err   <= 1'b0;
      end else begin
         rd_valid <= w_rd_acc;
         wr_err   <= wr_en & ~init_busy & w_prot;
         if (w_rd_acc) rd_data <= w_rd_word;
      end
   end

`ifdef DMEM_PARITY_EN
   logic r_par [DEPTH];
   logic w_rd_par;

   always_ff @(posedge clk) begin
      if (w_we) r_par[w_waddr] <= parity(64'(w_wdata));
   end

   assign w_rd_par = w_bypass ? parity(64'(wr_data)) : r_par[rd_addr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_perr <= 1'b0;
      else        rd_perr <= w_rd_acc & (parity(64'(w_rd_word)) != w_rd_par);
   end
`endif

endmodule
